// File: rtl/ami_pkg.sv
// Shared types and width defaults for the AXI read-request scheduler.
// Imported by the arbiter and the scheduler top level.
package ami_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_e;

    localparam int AXI_DW_DEF     = 128;
    localparam int AXI_AW_DEF     = 32;
    localparam int AXI_IW_DEF     = 8;
    localparam int AXI_LW_DEF     = 8;
    localparam int AXI_SW_DEF     = 3;
    localparam int AXI_BURSTW_DEF = 2;
    localparam int AXI_RRESPW_DEF = 2;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ami_rr_arb.sv
// Combinational round-robin arbiter: grants the first eligible requester
// at or after rr_ptr, wrapping modulo NREQ.
module ami_rr_arb
    import ami_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any_grant
);

    logic [IW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NREQ);
            if (!any_grant && eligible[cand]) begin
                any_grant   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ami_rd_sched.sv
// Shares one AXI read master between NREQ clients: round-robin AR issue
// tagged by ARID, RID-steered R return and per-client outstanding caps.
module ami_rd_sched
    import ami_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int AXI_DW     = AXI_DW_DEF,
    parameter int AXI_AW     = AXI_AW_DEF,
    parameter int AXI_IW     = AXI_IW_DEF,
    parameter int AXI_LW     = AXI_LW_DEF,
    parameter int AXI_SW     = AXI_SW_DEF,
    parameter int AXI_BURSTW = AXI_BURSTW_DEF,
    parameter int AXI_RRESPW = AXI_RRESPW_DEF,
    parameter int MAX_OUT    = 4
) (
    input  logic                             ACLK,
    input  logic                             ARESETn,
    input  logic [NREQ-1:0][AXI_AW-1:0]      req_araddr,
    input  logic [NREQ-1:0][AXI_LW-1:0]      req_arlen,
    input  logic [NREQ-1:0][AXI_SW-1:0]      req_arsize,
    input  logic [NREQ-1:0][AXI_BURSTW-1:0]  req_arburst,
    input  logic [NREQ-1:0]                  req_arvalid,
    output logic [NREQ-1:0]                  req_arready,
    output logic [AXI_DW-1:0]                req_rdata,
    output logic [AXI_RRESPW-1:0]            req_rresp,
    output logic                             req_rlast,
    output logic [NREQ-1:0]                  req_rvalid,
    input  logic [NREQ-1:0]                  req_rready,
    output logic [AXI_IW-1:0]                ARID,
    output logic [AXI_AW-1:0]                ARADDR,
    output logic [AXI_LW-1:0]                ARLEN,
    output logic [AXI_SW-1:0]                ARSIZE,
    output logic [AXI_BURSTW-1:0]            ARBURST,
    output logic                             ARVALID,
    input  logic                             ARREADY,
    input  logic [AXI_IW-1:0]                RID,
    input  logic [AXI_DW-1:0]                RDATA,
    input  logic [AXI_RRESPW-1:0]            RRESP,
    input  logic                             RLAST,
    input  logic                             RVALID,
    output logic                             RREADY,
    output logic                             err_rid
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

    sched_state_e                state_q, state_d;
    logic [IW-1:0]               rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]               win_q, win_d;
    logic                        arvalid_q, arvalid_d;
    logic [AXI_IW-1:0]           arid_q, arid_d;
    logic [AXI_AW-1:0]           araddr_q, araddr_d;
    logic [AXI_LW-1:0]           arlen_q, arlen_d;
    logic [AXI_SW-1:0]           arsize_q, arsize_d;
    logic [AXI_BURSTW-1:0]       arburst_q, arburst_d;
    logic [NREQ-1:0][CW-1:0]     ocnt_q, ocnt_d;
    logic                        err_rid_q, err_rid_d;

    logic [NREQ-1:0]             eligible;
    logic [NREQ-1:0]             grant;
    logic [IW-1:0]               grant_idx;
    logic                        any_grant;
    logic                        grant_fire;
    logic [IW-1:0]               rid_idx;
    logic                        rid_ok;
    logic                        rlast_fire;
    logic                        underflow;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_arvalid[i] && (ocnt_q[i] < MAX_OUT_C);
        end
    end

    ami_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign grant_fire  = (state_q == IDLE) && any_grant;
    assign req_arready = grant_fire ? grant : '0;

    // R steering is purely combinational; out-of-range IDs are sunk here.
    assign rid_idx = RID[IW-1:0];
    assign rid_ok  = ({1'b0, RID} < (AXI_IW + 1)'(NREQ));

    always_comb begin
        req_rvalid = '0;
        RREADY     = 1'b1;
        if (rid_ok) begin
            req_rvalid[rid_idx] = RVALID;
            RREADY              = req_rready[rid_idx];
        end
    end

    assign rlast_fire = RVALID && RREADY && RLAST && rid_ok;
    assign req_rdata  = RDATA;
    assign req_rresp  = RRESP;
    assign req_rlast  = RLAST;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        win_d     = win_q;
        arvalid_d = arvalid_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        unique case (state_q)
            IDLE: begin
                if (any_grant) begin
                    state_d   = HOLD;
                    arvalid_d = 1'b1;
                    win_d     = grant_idx;
                    arid_d    = AXI_IW'(grant_idx);
                    araddr_d  = req_araddr[grant_idx];
                    arlen_d   = req_arlen[grant_idx];
                    arsize_d  = req_arsize[grant_idx];
                    arburst_d = req_arburst[grant_idx];
                end
            end
            HOLD: begin
                if (ARREADY) begin
                    state_d   = IDLE;
                    arvalid_d = 1'b0;
                    rr_ptr_d  = IW'((int'(win_q) + 1) % NREQ);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A grant and an RLAST for the same requester cancel out.
    always_comb begin
        ocnt_d    = ocnt_q;
        underflow = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (rlast_fire && (rid_idx == IW'(i)) && (ocnt_q[i] == '0)) begin
                underflow = 1'b1;
            end
            if (grant_fire && grant[i] && !(rlast_fire && rid_idx == IW'(i))) begin
                ocnt_d[i] = ocnt_q[i] + CW'(1);
            end else if (!(grant_fire && grant[i]) && rlast_fire &&
                         (rid_idx == IW'(i)) && (ocnt_q[i] != '0)) begin
                ocnt_d[i] = ocnt_q[i] - CW'(1);
            end
        end
        err_rid_d = err_rid_q | (RVALID && !rid_ok) | underflow;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            win_q     <= '0;
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            ocnt_q    <= '0;
            err_rid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            win_q     <= win_d;
            arvalid_q <= arvalid_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            ocnt_q    <= ocnt_d;
            err_rid_q <= err_rid_d;
        end
    end

    assign ARVALID = arvalid_q;
    assign ARID    = arid_q;
    assign ARADDR  = araddr_q;
    assign ARLEN   = arlen_q;
    assign ARSIZE  = arsize_q;
    assign ARBURST = arburst_q;
    assign err_rid = err_rid_q;

endmodule

// File: tb/tb_ami_rd_sched.sv
// Self-checking bench for ami_rd_sched: directed scenarios plus a random run
// checked against a transaction-level reference model.
module tb_ami_rd_sched;

    localparam int NREQ = 4;
    localparam int IW   = 2;
    localparam int DW   = 128;
    localparam int AW   = 32;
    localparam int IDW  = 8;
    localparam int LW   = 8;
    localparam int SW   = 3;
    localparam int BW   = 2;
    localparam int RW   = 2;
    localparam int MAX_OUT = 2;

    logic                      ACLK = 1'b0;
    logic                      ARESETn;
    logic [NREQ-1:0][AW-1:0]   req_araddr;
    logic [NREQ-1:0][LW-1:0]   req_arlen;
    logic [NREQ-1:0][SW-1:0]   req_arsize;
    logic [NREQ-1:0][BW-1:0]   req_arburst;
    logic [NREQ-1:0]           req_arvalid;
    logic [NREQ-1:0]           req_arready;
    logic [DW-1:0]             req_rdata;
    logic [RW-1:0]             req_rresp;
    logic                      req_rlast;
    logic [NREQ-1:0]           req_rvalid;
    logic [NREQ-1:0]           req_rready;
    logic [IDW-1:0]            ARID;
    logic [AW-1:0]             ARADDR;
    logic [LW-1:0]             ARLEN;
    logic [SW-1:0]             ARSIZE;
    logic [BW-1:0]             ARBURST;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [IDW-1:0]            RID;
    logic [DW-1:0]             RDATA;
    logic [RW-1:0]             RRESP;
    logic                      RLAST;
    logic                      RVALID;
    logic                      RREADY;
    logic                      err_rid;

    int total = 0;
    int bad   = 0;

    ami_rd_sched #(
        .NREQ(NREQ), .AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IDW), .AXI_LW(LW),
        .AXI_SW(SW), .AXI_BURSTW(BW), .AXI_RRESPW(RW), .MAX_OUT(MAX_OUT)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arsize(req_arsize),
        .req_arburst(req_arburst), .req_arvalid(req_arvalid), .req_arready(req_arready),
        .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
        .req_rvalid(req_rvalid), .req_rready(req_rready),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY), .err_rid(err_rid)
    );

    always #5 ACLK = ~ACLK;

    // Reference model: pending AR, round-robin pointer, per-client outstanding counts.
    int              m_cnt[NREQ];
    int              m_ptr;
    bit              m_busy;
    int              m_w;
    logic [AW-1:0]   m_addr;
    logic [LW-1:0]   m_len;
    logic [SW-1:0]   m_size;
    logic [BW-1:0]   m_burst;
    bit              m_err;
    logic [NREQ-1:0] e_arready;
    logic [NREQ-1:0] e_rvalid;
    logic            e_rready;
    int              e_g;

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        m_ptr = 0; m_busy = 0; m_w = 0; m_err = 0;
        m_addr = '0; m_len = '0; m_size = '0; m_burst = '0;
    endtask

    task automatic eval();
        int r;
        e_arready = '0;
        e_g = -1;
        if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (e_g < 0 && ((req_arvalid >> j) & 4'b0001) != 0 && m_cnt[j] < MAX_OUT) e_g = j;
            end
        end
        if (e_g >= 0) e_arready = NREQ'(1) << e_g;
        r = int'(RID);
        e_rvalid = '0;
        e_rready = 1'b1;
        if (r < NREQ) begin
            e_rvalid = RVALID ? (NREQ'(1) << r) : '0;
            e_rready = |(req_rready & (NREQ'(1) << r));
        end
    endtask

    task automatic tick();
        logic [IW-1:0] gi;
        int r;
        bit dec;
        eval();
        r = int'(RID);
        dec = RVALID && (r < NREQ) && e_rready && RLAST;
        if (dec && m_cnt[r] == 0) m_err = 1;
        if (RVALID && r >= NREQ) m_err = 1;
        if (e_g >= 0) begin
            gi = e_g[IW-1:0];
            m_busy = 1; m_w = e_g;
            m_addr = req_araddr[gi]; m_len = req_arlen[gi];
            m_size = req_arsize[gi]; m_burst = req_arburst[gi];
            m_cnt[e_g]++;
        end else if (m_busy && ARREADY) begin
            m_busy = 0;
            m_ptr = (m_w + 1) % NREQ;
        end
        if (dec && m_cnt[r] > 0) m_cnt[r]--;
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic clear_inputs();
        req_araddr = '0; req_arlen = '0; req_arsize = '0; req_arburst = '0;
        req_arvalid = '0; req_rready = '0; ARREADY = 1'b0;
        RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge ACLK);
        total++; if (ARVALID !== 1'b0) begin bad++; $display("FAIL rst_arvalid: got %0h want 0", ARVALID); end
        total++; if (ARID !== '0) begin bad++; $display("FAIL rst_arid: got %0h want 0", ARID); end
        total++; if ({ARADDR, ARLEN, ARSIZE, ARBURST} !== '0) begin bad++; $display("FAIL rst_fields: got %0h want 0", {ARADDR, ARLEN, ARSIZE, ARBURST}); end
        total++; if (req_arready !== '0) begin bad++; $display("FAIL rst_arready: got %0h want 0", req_arready); end
        total++; if (err_rid !== 1'b0) begin bad++; $display("FAIL rst_err: got %0h want 0", err_rid); end
        total++; if (dut.ocnt_q !== '0) begin bad++; $display("FAIL rst_ocnt: got %0h want 0", dut.ocnt_q); end
        ARESETn = 1'b1;
        tick();
        total++; if (ARVALID !== 1'b0) begin bad++; $display("FAIL rst_idle: got %0h want 0", ARVALID); end
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        do_reset();
        req_araddr[2] = 32'h1000; req_arlen[2] = 8'd3; req_arsize[2] = 3'd4; req_arburst[2] = 2'd1;
        req_arvalid = 4'b0100;
        #1;
        total++; if (req_arready !== 4'b0100) begin bad++; $display("FAIL single_arready: got %0h want 4", req_arready); end
        total++; if (ARVALID !== 1'b0) begin bad++; $display("FAIL single_arvalid_early: got %0h want 0", ARVALID); end
        tick();
        req_arvalid = '0;
        total++; if (ARVALID !== 1'b1 || ARID !== 8'd2) begin bad++; $display("FAIL single_ar: got vld=%0h id=%0h want vld=1 id=2", ARVALID, ARID); end
        total++; if (ARADDR !== 32'h1000 || ARLEN !== 8'd3 || ARSIZE !== 3'd4 || ARBURST !== 2'd1) begin bad++; $display("FAIL single_fields: got %0h/%0h/%0h/%0h want 1000/3/4/1", ARADDR, ARLEN, ARSIZE, ARBURST); end
        total++; if (dut.ocnt_q[2] !== 2'd1) begin bad++; $display("FAIL single_ocnt_inc: got %0d want 1", dut.ocnt_q[2]); end
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        total++; if (ARVALID !== 1'b0) begin bad++; $display("FAIL single_ar_drop: got %0h want 0", ARVALID); end
        req_rready = '1;
        for (int b = 0; b < 4; b++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            RID = 8'd2; RVALID = 1'b1; RLAST = (b == 3); RDATA = d;
            #1;
            total++; if (req_rvalid !== 4'b0100 || RREADY !== 1'b1) begin bad++; $display("FAIL single_rbeat%0d: got rv=%0h rr=%0h want rv=4 rr=1", b, req_rvalid, RREADY); end
            total++; if (req_rdata !== d) begin bad++; $display("FAIL single_rdata%0d: got %0h want %0h", b, req_rdata, d); end
            if (b == 3) begin
                total++; if (dut.ocnt_q[2] !== 2'd1) begin bad++; $display("FAIL single_ocnt_hold: got %0d want 1", dut.ocnt_q[2]); end
            end
            tick();
        end
        RVALID = 1'b0; RLAST = 1'b0;
        total++; if (dut.ocnt_q[2] !== 2'd0 || err_rid !== 1'b0) begin bad++; $display("FAIL single_ocnt_dec: got ocnt=%0d err=%0h want 0/0", dut.ocnt_q[2], err_rid); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] want;
        do_reset();
        for (int i = 0; i < NREQ; i++) req_araddr[i] = $urandom;
        req_arvalid = '1;
        ARREADY = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            want = (c % 2 == 0) ? (4'b0001 << ((c / 2) % 4)) : 4'b0000;
            total++; if (req_arready !== want) begin bad++; $display("FAIL rr_grant_c%0d: got %0h want %0h", c, req_arready, want); end
            if (c % 2 == 1) begin
                total++; if (ARVALID !== 1'b1 || ARID !== 8'((c / 2) % 4)) begin bad++; $display("FAIL rr_arid_c%0d: got vld=%0h id=%0h want vld=1 id=%0h", c, ARVALID, ARID, (c / 2) % 4); end
            end
            tick();
        end
        req_arvalid = '0;
    endtask

    task automatic test_max_out();
        int g1, g3;
        bit seen;
        g1 = 0; g3 = 0; seen = 0;
        do_reset();
        req_arvalid = 4'b1010;
        ARREADY = 1'b1; req_rready = '1; RID = 8'd3; RLAST = 1'b1;
        for (int c = 0; c < 24; c++) begin
            RVALID = (m_cnt[3] > 0);
            #1;
            eval();
            total++; if (req_arready !== e_arready) begin bad++; $display("FAIL maxout_arready_c%0d: got %0h want %0h", c, req_arready, e_arready); end
            if (req_arready[1]) g1++;
            if (req_arready[3]) g3++;
            tick();
        end
        RVALID = 1'b0;
        total++; if (g1 != MAX_OUT) begin bad++; $display("FAIL maxout_grants1: got %0d want %0d", g1, MAX_OUT); end
        total++; if (g3 <= MAX_OUT) begin bad++; $display("FAIL maxout_grants3: got %0d want more than %0d", g3, MAX_OUT); end
        total++; if (dut.ocnt_q[1] !== 2'd2) begin bad++; $display("FAIL maxout_ocnt1: got %0d want 2", dut.ocnt_q[1]); end
        RID = 8'd1; RVALID = 1'b1; RLAST = 1'b1;
        #1;
        total++; if (req_rvalid !== 4'b0010 || RREADY !== 1'b1) begin bad++; $display("FAIL maxout_rlast1: got rv=%0h rr=%0h want rv=2 rr=1", req_rvalid, RREADY); end
        tick();
        RVALID = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            #1;
            if (req_arready[1]) seen = 1;
            tick();
        end
        total++; if (!seen) begin bad++; $display("FAIL maxout_reenable: got no grant to 1 within 6 cycles want a grant"); end
        req_arvalid = '0; RLAST = 1'b0;
    endtask

    task automatic test_hold();
        logic [AW-1:0] a;
        logic [LW-1:0] l;
        logic [SW-1:0] s;
        logic [BW-1:0] bu;
        do_reset();
        a = $urandom; l = 8'($urandom); s = 3'($urandom); bu = 2'($urandom);
        req_araddr[0] = a; req_arlen[0] = l; req_arsize[0] = s; req_arburst[0] = bu;
        req_arvalid = 4'b0001;
        #1;
        total++; if (req_arready !== 4'b0001) begin bad++; $display("FAIL hold_grant: got %0h want 1", req_arready); end
        tick();
        for (int c = 0; c < 5; c++) begin
            req_arvalid = '1;
            for (int i = 0; i < NREQ; i++) begin
                req_araddr[i] = $urandom; req_arlen[i] = 8'($urandom);
                req_arsize[i] = 3'($urandom); req_arburst[i] = 2'($urandom);
            end
            #1;
            total++; if (req_arready !== '0) begin bad++; $display("FAIL hold_arready_c%0d: got %0h want 0", c, req_arready); end
            total++; if (ARVALID !== 1'b1 || ARID !== 8'd0 || ARADDR !== a || ARLEN !== l || ARSIZE !== s || ARBURST !== bu) begin
                bad++; $display("FAIL hold_stable_c%0d: got vld=%0h id=%0h a=%0h l=%0h s=%0h b=%0h want 1/0/%0h/%0h/%0h/%0h", c, ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, a, l, s, bu);
            end
            tick();
        end
        ARREADY = 1'b1;
        #1;
        total++; if (ARVALID !== 1'b1 || req_arready !== '0) begin bad++; $display("FAIL hold_hs_cycle: got vld=%0h rdy=%0h want 1/0", ARVALID, req_arready); end
        tick();
        ARREADY = 1'b0; req_arvalid = '0;
        total++; if (ARVALID !== 1'b0) begin bad++; $display("FAIL hold_release: got %0h want 0", ARVALID); end
    endtask

    task automatic test_bad_rid();
        do_reset();
        RID = 8'd7; RVALID = 1'b1; RLAST = 1'b1; req_rready = '0;
        #1;
        total++; if (RREADY !== 1'b1 || req_rvalid !== '0) begin bad++; $display("FAIL badrid_route: got rr=%0h rv=%0h want rr=1 rv=0", RREADY, req_rvalid); end
        tick();
        RVALID = 1'b0;
        total++; if (err_rid !== 1'b1) begin bad++; $display("FAIL badrid_err: got %0h want 1", err_rid); end
        tick();
        total++; if (err_rid !== 1'b1) begin bad++; $display("FAIL badrid_sticky: got %0h want 1", err_rid); end
        do_reset();
        total++; if (err_rid !== 1'b0) begin bad++; $display("FAIL badrid_clear: got %0h want 0", err_rid); end
        RID = 8'd2; RVALID = 1'b1; RLAST = 1'b1; req_rready = '1;
        #1;
        total++; if (req_rvalid !== 4'b0100) begin bad++; $display("FAIL underflow_route: got %0h want 4", req_rvalid); end
        tick();
        RVALID = 1'b0;
        total++; if (err_rid !== 1'b1 || dut.ocnt_q[2] !== 2'd0) begin bad++; $display("FAIL underflow_err: got err=%0h ocnt=%0d want 1/0", err_rid, dut.ocnt_q[2]); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        req_arvalid = 4'b0001;
        tick();
        req_arvalid = '0; ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        total++; if (dut.ocnt_q[0] !== 2'd1) begin bad++; $display("FAIL same_pre: got %0d want 1", dut.ocnt_q[0]); end
        req_arvalid = 4'b0001;
        RID = 8'd0; RVALID = 1'b1; RLAST = 1'b1; req_rready = 4'b0001;
        #1;
        total++; if (req_arready !== 4'b0001 || req_rvalid !== 4'b0001) begin bad++; $display("FAIL same_both: got rdy=%0h rv=%0h want 1/1", req_arready, req_rvalid); end
        tick();
        RVALID = 1'b0; RLAST = 1'b0; req_arvalid = '0;
        total++; if (dut.ocnt_q[0] !== 2'd1 || ARVALID !== 1'b1) begin bad++; $display("FAIL same_ocnt: got ocnt=%0d vld=%0h want 1/1", dut.ocnt_q[0], ARVALID); end
        #2;
        ARESETn = 1'b0;
        #1;
        total++; if (ARVALID !== 1'b0 || dut.ocnt_q !== '0 || ARID !== '0) begin bad++; $display("FAIL async_rst: got vld=%0h ocnt=%0h id=%0h want 0/0/0", ARVALID, dut.ocnt_q, ARID); end
        model_reset();
        @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req_arvalid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                req_araddr[i] = $urandom; req_arlen[i] = 8'($urandom);
                req_arsize[i] = 3'($urandom); req_arburst[i] = 2'($urandom);
            end
            ARREADY = ($urandom_range(0, 2) != 0);
            req_rready = NREQ'($urandom);
            RVALID = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 63) == 0) ? NREQ + $urandom_range(0, 3) : $urandom_range(0, NREQ - 1);
            RID = 8'(r);
            RLAST = (r < NREQ && m_cnt[r] > 0) ? 1'($urandom) : ($urandom_range(0, 19) == 0);
            RDATA = {$urandom, $urandom, $urandom, $urandom};
            RRESP = 2'($urandom);
            #1;
            eval();
            total++; if (req_arready !== e_arready) begin bad++; $display("FAIL rnd_arready_c%0d: got %0h want %0h", c, req_arready, e_arready); end
            total++; if (req_rvalid !== e_rvalid || RREADY !== e_rready) begin bad++; $display("FAIL rnd_r_c%0d: got rv=%0h rr=%0h want rv=%0h rr=%0h", c, req_rvalid, RREADY, e_rvalid, e_rready); end
            total++; if (req_rdata !== RDATA || req_rresp !== RRESP || req_rlast !== RLAST) begin bad++; $display("FAIL rnd_bcast_c%0d: got %0h/%0h/%0h want %0h/%0h/%0h", c, req_rdata, req_rresp, req_rlast, RDATA, RRESP, RLAST); end
            tick();
            total++; if (ARVALID !== m_busy || ARID !== 8'(m_w)) begin bad++; $display("FAIL rnd_ar_c%0d: got vld=%0h id=%0h want vld=%0h id=%0h", c, ARVALID, ARID, m_busy, m_w); end
            total++; if (ARADDR !== m_addr || ARLEN !== m_len || ARSIZE !== m_size || ARBURST !== m_burst) begin bad++; $display("FAIL rnd_fields_c%0d: got %0h/%0h/%0h/%0h want %0h/%0h/%0h/%0h", c, ARADDR, ARLEN, ARSIZE, ARBURST, m_addr, m_len, m_size, m_burst); end
            total++; if (err_rid !== m_err) begin bad++; $display("FAIL rnd_err_c%0d: got %0h want %0h", c, err_rid, m_err); end
            for (int i = 0; i < NREQ; i++) begin
                total++; if (dut.ocnt_q[i] !== 2'(m_cnt[i])) begin bad++; $display("FAIL rnd_ocnt%0d_c%0d: got %0d want %0d", i, c, dut.ocnt_q[i], m_cnt[i]); end
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_max_out();
        test_hold();
        test_bad_rid();
        test_same_cycle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion want completion within 2000000 time units");
        $fatal(1, "bench did not complete");
    end

endmodule
